pll_reset_ce_gen: RTL and testbench
===================================

PLL_RESET_CE_GEN -- requirements
Module: pll_reset_ce_gen

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, meaning the consecutive cycles of synchronised lock required before the reset hold begins (legal range 2..65536).
REQ-002 SHALL have parameter RESET_HOLD_CYCLES, default 16, meaning the cycles core_reset stays high after lock is stable or after a soft reset (legal range 1..256).
REQ-003 SHALL have port clk_sys  input  1  18 MHz system clock taken from PLL outclk_0; the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high block reset.
REQ-005 SHALL have port pll_locked  input  1  PLL lock flag; asynchronous to clk_sys.
REQ-006 SHALL have port soft_reset_req  input  1  level request from the OSD/menu to reset the core.
REQ-007 SHALL have port core_reset  output  1  active-high reset for the downstream core.
REQ-008 SHALL have port ce_6m  output  1  single-cycle pixel clock enable, 1 in 3 cycles.
REQ-009 SHALL have port ce_3m  output  1  single-cycle CPU clock enable, 1 in 6 cycles.
REQ-010 SHALL have port state  output  2  current FSM state encoding.
REQ-011 SHALL have port lock_lost_cnt  output  8  saturating count of lock losses while in RUN.

Function
REQ-012 SHALL synchronise pll_locked through two clk_sys flops (sync1, then lock_s); only lock_s is used internally.
REQ-013 SHALL implement the FSM states WAIT_LOCK=0, STABILIZE=1, HOLD=2, RUN=3, with state driven directly from the state register.
REQ-014 WAIT_LOCK: counter held at 0; when lock_s=1, next state SHALL be STABILIZE.
REQ-015 STABILIZE: counter SHALL increment by 1 each cycle; lock_s=0 -> WAIT_LOCK with counter cleared; counter=LOCK_STABLE_CYCLES-1 with lock_s=1 -> HOLD with counter cleared, so STABILIZE lasts exactly LOCK_STABLE_CYCLES cycles.
REQ-016 HOLD: counter SHALL increment each cycle; counter=RESET_HOLD_CYCLES-1 -> RUN with counter cleared; HOLD lasts exactly RESET_HOLD_CYCLES cycles.
REQ-017 In HOLD, soft_reset_req=1 SHALL clear the counter and remain in HOLD, so the hold restarts each cycle the request is high.
REQ-018 RUN: lock_s=0 -> WAIT_LOCK; otherwise soft_reset_req=1 -> HOLD with counter cleared.
REQ-019 Loss of lock SHALL take priority over soft_reset_req in every state.
REQ-020 The state counter SHALL be 16 bits wide and SHALL never exceed its terminal value.
REQ-021 core_reset SHALL be 1 whenever the state register is not RUN, and 0 in RUN; it is a Moore decode with no combinational path from any input.
REQ-022 The enable divider SHALL be a 3-bit counter div cycling 0..5 and wrapping 5 -> 0, advancing only in RUN and forced to 0 in all other states.
REQ-023 ce_6m SHALL be 1 exactly when state=RUN and div is 0 or 3; ce_3m SHALL be 1 exactly when state=RUN and div=0, so ce_3m is always coincident with a ce_6m.
REQ-024 The first RUN cycle SHALL carry div=0, so ce_6m=ce_3m=1 on it.
REQ-025 lock_lost_cnt SHALL increment on each RUN->WAIT_LOCK transition, saturate at 255, and be cleared only by reset.
REQ-026 Latency: with pll_locked first sampled high at edge k and held high, state SHALL be STABILIZE at edge k+2 and RUN at edge k+2+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES.

Reset
REQ-027 reset=1 at a clk_sys edge SHALL set state=WAIT_LOCK, sync1=lock_s=0, counter=0, div=0, lock_lost_cnt=0.
REQ-028 While reset is asserted, outputs SHALL be core_reset=1, ce_6m=0, ce_3m=0.
REQ-029 reset asserted mid-operation in any state SHALL take effect on the next edge, overriding all other inputs.
REQ-030 After reset is released, the block SHALL restart the full lock sequence; a previously reached RUN state is not retained.

Verification (bench uses LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4)
REQ-031 Power-up: pll_locked rises and is first sampled at edge k, then held -> state=1 at k+2, 2 at k+10, 3 at k+14; core_reset falls at k+14; ce_3m=1 at k+14 and k+20; ce_6m=1 at k+14, k+17, k+20.
REQ-032 Glitch: pll_locked low for 1 cycle during STABILIZE -> state returns to 0 and the counter restarts; RUN is reached 12 cycles after lock_s returns high; lock_lost_cnt stays 0.
REQ-033 Soft reset: soft_reset_req high for 3 cycles in RUN -> core_reset=1 and the ces stop the next cycle; RUN resumes 4 cycles after soft_reset_req is last sampled high.
REQ-034 Lock loss in RUN, repeated 300 times -> each loss gives WAIT_LOCK, core_reset=1 and ce=0; lock_lost_cnt reads 255 and does not wrap.
REQ-035 Simultaneous events: lock_s=0 and soft_reset_req=1 together in RUN -> next state=0, not 2; reset asserted in HOLD -> state=0 and lock_lost_cnt=0 the next cycle.

Source files
------------

// File: rtl/pll_reset_ce_gen.sv
// Reset sequencer and clock-enable generator for a core running from PLL outclk_0.
// Holds core_reset until lock has been stable, then divides clk_sys into 6 MHz / 3 MHz enables.
module pll_reset_ce_gen #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       core_reset,
  output logic       ce_6m,
  output logic       ce_3m,
  output logic [1:0] state,
  output logic [7:0] lock_lost_cnt
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(RESET_HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  div_q, div_d;
  logic        sync1, lock_s;
  logic        lock_loss_evt;

  // pll_locked is asynchronous to clk_sys, so only the second flop is trusted
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked;
      lock_s <= sync1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = STABILIZE;
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (soft_reset_req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) state_d = WAIT_LOCK;
        else if (soft_reset_req) state_d = HOLD;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // The divider only runs while staying in RUN, so every RUN entry starts at div=0
  always_comb begin
    div_d = '0;
    if (state_q == RUN && state_d == RUN) begin
      div_d = (div_q == 3'd5) ? 3'd0 : div_q + 3'd1;
    end
  end

  assign lock_loss_evt = (state_q == RUN) && (state_d == WAIT_LOCK);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= WAIT_LOCK;
      cnt_q         <= '0;
      div_q         <= '0;
      lock_lost_cnt <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      if (lock_loss_evt && lock_lost_cnt != 8'hFF) begin
        lock_lost_cnt <= lock_lost_cnt + 8'd1;
      end
    end
  end

  assign state      = state_q;
  assign core_reset = (state_q != RUN);
  assign ce_6m      = (state_q == RUN) && (div_q == 3'd0 || div_q == 3'd3);
  assign ce_3m      = (state_q == RUN) && (div_q == 3'd0);

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Self-checking bench for pll_reset_ce_gen with a timeline-based reference model.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_pll_reset_ce_gen;

  localparam int LSC = 8;
  localparam int RHC = 4;

  logic       clk_sys        = 1'b0;
  logic       reset          = 1'b1;
  logic       pll_locked     = 1'b0;
  logic       soft_reset_req = 1'b0;
  logic       core_reset;
  logic       ce_6m;
  logic       ce_3m;
  logic [1:0] state;
  logic [7:0] lock_lost_cnt;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  int m_s1 = 0, m_s2 = 0, m_len = 0, m_state = 0, m_prev = 0;
  int m_lost = 0, m_run_ok = 0, m_run_entry = 0;
  logic [12:0] m_vec = 13'b0;

  pll_reset_ce_gen #(
    .LOCK_STABLE_CYCLES(LSC),
    .RESET_HOLD_CYCLES (RHC)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .pll_locked    (pll_locked),
    .soft_reset_req(soft_reset_req),
    .core_reset    (core_reset),
    .ce_6m         (ce_6m),
    .ce_3m         (ce_3m),
    .state         (state),
    .lock_lost_cnt (lock_lost_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: the state follows from how long lock has been seen and
  // from the edge at which the latest reset hold is allowed to end.
  always @(posedge clk_sys) begin
    edge_n = edge_n + 1;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_len = 0; m_state = 0; m_lost = 0; m_run_ok = 0;
    end else begin
      m_prev = m_state;
      if (m_s2 == 0) m_len = 0;
      else m_len = m_len + 1;
      if (m_len == LSC + 1 || (m_len > LSC + 1 && soft_reset_req)) m_run_ok = edge_n + RHC;
      if (m_len == 0) m_state = 0;
      else if (m_len <= LSC) m_state = 1;
      else if (edge_n < m_run_ok) m_state = 2;
      else m_state = 3;
      if (m_prev == 3 && m_state == 0 && m_lost < 255) m_lost = m_lost + 1;
      if (m_state == 3 && m_prev != 3) m_run_entry = edge_n;
      m_s2 = m_s1;
      m_s1 = pll_locked ? 1 : 0;
    end
    m_vec = {2'(m_state), (m_state != 3),
             (m_state == 3) && ((edge_n - m_run_entry) % 3 == 0),
             (m_state == 3) && ((edge_n - m_run_entry) % 6 == 0),
             8'(m_lost)};
  end

  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_locked = 1'b0; soft_reset_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({state, core_reset, ce_6m, ce_3m, lock_lost_cnt} !== 13'b00_1_0_0_00000000) begin
        failures++;
        $display("[TB] FAIL reset_state got=%b want=%b", {state, core_reset, ce_6m, ce_3m, lock_lost_cnt}, 13'b00_1_0_0_00000000);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_power_up();
    int k, e, d;
    logic [4:0] want;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({state, core_reset, ce_6m, ce_3m, lock_lost_cnt} !== m_vec) begin
        failures++;
        $display("[TB] FAIL powerup_idle got=%b want=%b", {state, core_reset, ce_6m, ce_3m, lock_lost_cnt}, m_vec);
      end
    end
    pll_locked = 1'b1;
    k = edge_n + 1;
    for (int i = 0; i < 24; i++) begin
      step();
      e = edge_n;
      d = e - (k + 14);
      want[4:3] = (e < k + 2) ? 2'd0 : (e < k + 10) ? 2'd1 : (e < k + 14) ? 2'd2 : 2'd3;
      want[2]   = (e < k + 14);
      want[1]   = (d >= 0) && (d % 3 == 0);
      want[0]   = (d >= 0) && (d % 6 == 0);
      checks++;
      if ({state, core_reset, ce_6m, ce_3m} !== want) begin
        failures++;
        $display("[TB] FAIL powerup_timeline edge=k+%0d got=%b want=%b", e - k, {state, core_reset, ce_6m, ce_3m}, want);
      end
      checks++;
      if ({state, core_reset, ce_6m, ce_3m, lock_lost_cnt} !== m_vec) begin
        failures++;
        $display("[TB] FAIL powerup_model got=%b want=%b", {state, core_reset, ce_6m, ce_3m, lock_lost_cnt}, m_vec);
      end
    end
  endtask

  task automatic test_glitch();
    bit saw_wait = 0;
    int e1 = -1, er = -1;
    reset = 1'b1; pll_locked = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 10 && state !== 2'd1; i++) step();
    checks++;
    if (state !== 2'd1) begin
      failures++;
      $display("[TB] FAIL glitch_reach_stabilize got=%0d want=1", state);
    end
    step(); step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    for (int i = 0; i < 40 && er < 0; i++) begin
      step();
      checks++;
      if ({state, core_reset, ce_6m, ce_3m, lock_lost_cnt} !== m_vec) begin
        failures++;
        $display("[TB] FAIL glitch_model got=%b want=%b", {state, core_reset, ce_6m, ce_3m, lock_lost_cnt}, m_vec);
      end
      if (state === 2'd0) saw_wait = 1;
      if (saw_wait && state === 2'd1 && e1 < 0) e1 = edge_n;
      if (saw_wait && state === 2'd3) er = edge_n;
    end
    checks++;
    if (!saw_wait || e1 < 0 || er < 0 || er - e1 != 12) begin
      failures++;
      $display("[TB] FAIL glitch_restart saw_wait=%0d run_after_lock=%0d want=12", saw_wait, er - e1);
    end
    checks++;
    if (lock_lost_cnt !== 8'd0) begin
      failures++;
      $display("[TB] FAIL glitch_lost_cnt got=%0d want=0", lock_lost_cnt);
    end
  endtask

  task automatic test_soft_reset();
    int j, w;
    w = int'($urandom_range(0, 7));
    for (int i = 0; i < w; i++) step();
    soft_reset_req = 1'b1;
    j = edge_n + 1;
    step();
    checks++;
    if ({state, core_reset, ce_6m, ce_3m} !== 5'b10_1_0_0) begin
      failures++;
      $display("[TB] FAIL soft_enter_hold got=%b want=%b", {state, core_reset, ce_6m, ce_3m}, 5'b10_1_0_0);
    end
    step(); step();
    soft_reset_req = 1'b0;
    for (int e = j + 3; e <= j + 8; e++) begin
      step();
      checks++;
      if (state !== ((e < j + 6) ? 2'd2 : 2'd3) || (e == j + 6 && {ce_6m, ce_3m} !== 2'b11)) begin
        failures++;
        $display("[TB] FAIL soft_resume edge=j+%0d got_state=%0d got_ce=%b", e - j, state, {ce_6m, ce_3m});
      end
      checks++;
      if ({state, core_reset, ce_6m, ce_3m, lock_lost_cnt} !== m_vec) begin
        failures++;
        $display("[TB] FAIL soft_model got=%b want=%b", {state, core_reset, ce_6m, ce_3m, lock_lost_cnt}, m_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      pll_locked     = ($urandom_range(0, 19) != 0);
      soft_reset_req = ($urandom_range(0, 9) == 0);
      step();
      checks++;
      if ({state, core_reset, ce_6m, ce_3m, lock_lost_cnt} !== m_vec) begin
        failures++;
        $display("[TB] FAIL random_model edge=%0d got=%b want=%b", edge_n, {state, core_reset, ce_6m, ce_3m, lock_lost_cnt}, m_vec);
      end
    end
    pll_locked = 1'b1; soft_reset_req = 1'b0;
  endtask

  task automatic test_lock_loss_saturation();
    int w, d, a;
    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < 40 && state !== 2'd3; i++) begin
        step();
        checks++;
        if ({state, core_reset, ce_6m, ce_3m, lock_lost_cnt} !== m_vec) begin
          failures++;
          $display("[TB] FAIL sat_model edge=%0d got=%b want=%b", edge_n, {state, core_reset, ce_6m, ce_3m, lock_lost_cnt}, m_vec);
        end
      end
      checks++;
      if (state !== 2'd3) begin
        failures++;
        $display("[TB] FAIL sat_reach_run iter=%0d got=%0d want=3", it, state);
        return;
      end
      w = int'($urandom_range(0, 5));
      d = int'($urandom_range(1, 3));
      for (int i = 0; i < w; i++) step();
      pll_locked = 1'b0;
      a = edge_n + 1;
      for (int i = 0; i < d; i++) step();
      pll_locked = 1'b1;
      while (edge_n < a + 2) step();
      checks++;
      if ({state, core_reset, ce_6m, ce_3m} !== 5'b00_1_0_0 || lock_lost_cnt !== 8'(m_lost)) begin
        failures++;
        $display("[TB] FAIL sat_loss iter=%0d got=%b lost=%0d want=00100 lost=%0d", it, {state, core_reset, ce_6m, ce_3m}, lock_lost_cnt, m_lost);
      end
    end
    checks++;
    if (lock_lost_cnt !== 8'd255) begin
      failures++;
      $display("[TB] FAIL sat_final got=%0d want=255", lock_lost_cnt);
    end
  endtask

  task automatic test_simultaneous();
    int r, er = -1;
    for (int i = 0; i < 40 && state !== 2'd3; i++) step();
    pll_locked = 1'b0;
    step(); step();
    soft_reset_req = 1'b1;
    step();
    soft_reset_req = 1'b0;
    pll_locked = 1'b1;
    checks++;
    if (state !== 2'd0 || core_reset !== 1'b1 || lock_lost_cnt !== 8'd255) begin
      failures++;
      $display("[TB] FAIL simul_loss_vs_soft got_state=%0d lost=%0d want_state=0 lost=255", state, lock_lost_cnt);
    end
    for (int i = 0; i < 20 && state !== 2'd2; i++) begin
      step();
      checks++;
      if ({state, core_reset, ce_6m, ce_3m, lock_lost_cnt} !== m_vec) begin
        failures++;
        $display("[TB] FAIL simul_model got=%b want=%b", {state, core_reset, ce_6m, ce_3m, lock_lost_cnt}, m_vec);
      end
    end
    checks++;
    if (state !== 2'd2) begin
      failures++;
      $display("[TB] FAIL simul_reach_hold got=%0d want=2", state);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({state, core_reset, ce_6m, ce_3m, lock_lost_cnt} !== 13'b00_1_0_0_00000000) begin
        failures++;
        $display("[TB] FAIL reset_in_hold got=%b want=%b", {state, core_reset, ce_6m, ce_3m, lock_lost_cnt}, 13'b00_1_0_0_00000000);
      end
    end
    reset = 1'b0;
    r = edge_n;
    for (int i = 0; i < 30 && er < 0; i++) begin
      step();
      checks++;
      if ({state, core_reset, ce_6m, ce_3m, lock_lost_cnt} !== m_vec) begin
        failures++;
        $display("[TB] FAIL restart_model got=%b want=%b", {state, core_reset, ce_6m, ce_3m, lock_lost_cnt}, m_vec);
      end
      if (state === 2'd3) er = edge_n;
    end
    checks++;
    if (er - r != 15) begin
      failures++;
      $display("[TB] FAIL restart_latency got=%0d want=15", er - r);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout at edge %0d", edge_n);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_soft_reset();
    test_random();
    test_lock_loss_saturation();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
